// File: rtl/qpu_ifu_ibuf.sv
// qpu_ifu_ibuf: instruction buffer between the IFU and the EXU.
// This is a circular FIFO of DEPTH entries. The head entry is held in an output
// register, so an instruction pushed in cycle N first appears on o_* in cycle N+1.
// flush_req empties the buffer and drops any instruction offered in the same cycle.

`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_RFIDX_WIDTH
`define QPU_RFIDX_WIDTH 5
`endif

module qpu_ifu_ibuf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [`QPU_INSTR_SIZE-1:0]  i_ir,
  input  logic [`QPU_PC_SIZE-1:0]     i_pc,
  input  logic                        i_pc_vld,
  input  logic [`QPU_RFIDX_WIDTH-1:0] i_rs1idx,
  input  logic [`QPU_RFIDX_WIDTH-1:0] i_rs2idx,
  input  logic                        i_prdt_taken,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [`QPU_INSTR_SIZE-1:0]  o_ir,
  output logic [`QPU_PC_SIZE-1:0]     o_pc,
  output logic                        o_pc_vld,
  output logic [`QPU_RFIDX_WIDTH-1:0] o_rs1idx,
  output logic [`QPU_RFIDX_WIDTH-1:0] o_rs2idx,
  output logic                        o_prdt_taken,
  input  logic                        flush_req,
  output logic                        flush_ack,
  output logic [CNT_W-1:0]            ibuf_cnt,
  output logic                        ibuf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [`QPU_INSTR_SIZE-1:0]  ir;
    logic [`QPU_PC_SIZE-1:0]     pc;
    logic                        pc_vld;
    logic [`QPU_RFIDX_WIDTH-1:0] rs1idx;
    logic [`QPU_RFIDX_WIDTH-1:0] rs2idx;
    logic                        prdt_taken;
  } ibuf_entry_t;

  ibuf_entry_t       mem_r [DEPTH];
  ibuf_entry_t       head_r;
  ibuf_entry_t       wr_entry_s;
  ibuf_entry_t       head_nxt_s;
  logic              head_load_s;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  remain_s;
  logic              push_s;
  logic              pop_s;

  // The handshakes depend only on registered occupancy and flush_req.
  // There is no path from o_ready to i_ready or from i_valid to o_valid.
  assign i_ready    = (cnt_r != FULL_CNT) & ~flush_req;
  assign o_valid    = (cnt_r != {CNT_W{1'b0}});
  assign flush_ack  = flush_req;
  assign ibuf_cnt   = cnt_r;
  assign ibuf_empty = (cnt_r == {CNT_W{1'b0}});
  assign push_s     = i_valid & i_ready;
  assign pop_s      = o_valid & o_ready & ~flush_req;

  assign wr_entry_s = '{ir: i_ir, pc: i_pc, pc_vld: i_pc_vld, rs1idx: i_rs1idx,
                        rs2idx: i_rs2idx, prdt_taken: i_prdt_taken};

  assign {o_ir, o_pc, o_pc_vld, o_rs1idx, o_rs2idx, o_prdt_taken} = head_r;

  // Work out which entry becomes the head in the next cycle. If the buffer is
  // about to run dry, the head is taken straight from the entry being pushed.
  always_comb begin
    rd_nxt_s    = rd_ptr_r;
    remain_s    = cnt_r;
    head_nxt_s  = head_r;
    head_load_s = 1'b0;
    if (pop_s) begin
      rd_nxt_s = rd_ptr_r + PTR_W'(1);
      remain_s = cnt_r - CNT_W'(1);
    end else begin
      rd_nxt_s = rd_ptr_r;
      remain_s = cnt_r;
    end
    if (remain_s != {CNT_W{1'b0}}) begin
      head_nxt_s  = mem_r[rd_nxt_s];
      head_load_s = 1'b1;
    end else if (push_s) begin
      head_nxt_s  = wr_entry_s;
      head_load_s = 1'b1;
    end else begin
      head_nxt_s  = head_r;
      head_load_s = 1'b0;
    end
  end

  // Update the pointers and occupancy. Flush takes priority over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (flush_req) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Store the entry storage and the registered head entry.
  // The head register keeps its last value while the buffer is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      head_r <= '0;
    end else begin
      if (push_s) mem_r[wr_ptr_r] <= wr_entry_s;
      if (head_load_s && !flush_req) head_r <= head_nxt_s;
    end
  end

endmodule

// File: doc/qpu_ifu_ibuf.md
QPU_IFU_IBUF -- requirements
Module: qpu_ifu_ibuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, width of the occupancy count, equal to log2(DEPTH)+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1 bit: upstream IFU offers an instruction.
REQ-006 SHALL have port i_ready, output, 1 bit: buffer accepts the offered instruction.
REQ-007 SHALL have port i_ir, input, `QPU_INSTR_SIZE bits: instruction word.
REQ-008 SHALL have port i_pc, input, `QPU_PC_SIZE bits: instruction PC.
REQ-009 SHALL have port i_pc_vld, input, 1 bit: PC valid flag.
REQ-010 SHALL have ports i_rs1idx and i_rs2idx, input, `QPU_RFIDX_WIDTH bits each: source register indexes.
REQ-011 SHALL have port i_prdt_taken, input, 1 bit: branch predicted taken.
REQ-012 SHALL have ports o_valid (output, 1 bit) and o_ready (input, 1 bit): EXU-side handshake.
REQ-013 SHALL have outputs o_ir, o_pc, o_pc_vld, o_rs1idx, o_rs2idx and o_prdt_taken, with the same widths as the matching i_* ports, presenting the head entry.
REQ-014 SHALL have port flush_req, input, 1 bit: discard all buffered instructions.
REQ-015 SHALL have port flush_ack, output, 1 bit: flush accepted.
REQ-016 SHALL have port ibuf_cnt, output, CNT_W bits: current occupancy.
REQ-017 SHALL have port ibuf_empty, output, 1 bit: occupancy is zero; consumed by the halt-acknowledge logic.

Function
REQ-018 SHALL store entries in a circular FIFO with read and write pointers of log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-019 SHALL drive i_ready = (ibuf_cnt != DEPTH) & ~flush_req, with no combinational path from o_ready.
REQ-020 SHALL push when i_valid & i_ready: the entry is written at the write pointer and the write pointer is incremented.
REQ-021 SHALL drive o_valid = (ibuf_cnt != 0), registered state only, with no path from i_valid.
REQ-022 SHALL pop when o_valid & o_ready & ~flush_req, incrementing the read pointer.
REQ-023 SHALL give latency of exactly 1 cycle: an instruction pushed in cycle N is first visible on o_* in cycle N+1; there is no bypass.
REQ-024 SHALL, on simultaneous push and pop, leave ibuf_cnt unchanged, both pointers advance.
REQ-025 SHALL keep o_* stable while o_valid & ~o_ready, and hold them at the last value when empty (content don't-care).
REQ-026 SHALL give flush_req priority over push and pop: the next cycle sees pointers = 0, ibuf_cnt = 0, o_valid = 0; a same-cycle offered instruction is dropped and not acknowledged.
REQ-027 SHALL drive flush_ack = flush_req combinationally; a multi-cycle flush_req keeps the buffer empty and i_ready low.
REQ-028 SHALL guarantee that ibuf_cnt never exceeds DEPTH nor underflows below 0.
REQ-029 SHALL drive ibuf_empty = (ibuf_cnt == 0).

Reset
REQ-030 SHALL, on rst assertion, immediately and asynchronously clear pointers and ibuf_cnt, giving o_valid = 0, ibuf_empty = 1, i_ready = 1 (if flush_req = 0), and o_* = 0.
REQ-031 SHALL discard buffered entries when rst is asserted mid-operation, producing no o_valid pulse after release.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-033 SHALL pass Fill: DEPTH=4, o_ready=0, push 5 instructions with pc 0x0,0x4,0x8,0xC,0x10 -> 4 accepted, i_ready=0 on the 5th, ibuf_cnt=4.
REQ-034 SHALL pass Drain order: after Fill, o_ready=1 -> o_pc sequence 0x0,0x4,0x8,0xC on 4 consecutive cycles, then o_valid=0, ibuf_empty=1.
REQ-035 SHALL pass Streaming: i_valid=1 and o_ready=1 continuously for 20 cycles -> ibuf_cnt settles at 1, throughput is 1 per cycle, pointers wrap correctly, no loss or duplication.
REQ-036 SHALL pass Flush with push: ibuf_cnt=3, flush_req=1 for one cycle with i_valid=1 -> flush_ack=1, i_ready=0, next cycle ibuf_cnt=0, o_valid=0, and the offered instruction never appears.
REQ-037 SHALL pass Backpressure: o_valid=1, o_ready=0 for 5 cycles -> o_ir/o_pc unchanged across all 5 cycles.
REQ-038 SHALL pass Async reset: rst pulsed between clock edges with ibuf_cnt=2 -> o_valid=0 and ibuf_cnt=0 immediately, with no stale output after release.
